// File: rtl/arith_result_checker_pkg.sv
// Shared definitions for the arithmetic result checker: mismatch mask layout,
// FSM state encoding and the divide-by-zero convention used by every divider model.
package arith_result_checker_pkg;

  // Per-unit mismatch mask layout.
  localparam int MASK_W    = 6;
  localparam int MASK_CMP  = 0;  // lt/gt/eq comparators
  localparam int MASK_ADD  = 1;  // sum and carry
  localparam int MASK_SUB  = 2;  // diff and borrow
  localparam int MASK_MUL  = 3;  // product low and high halves
  localparam int MASK_QUOT = 4;  // divider quotient
  localparam int MASK_REM  = 5;  // divider remainder

  // Divide by zero: quotient is all ones, remainder is the dividend.
  localparam bit DIV0_QUOT_ALL_ONES = 1'b1;

  // Run-control FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/arith_result_checker_golden.sv
// Combinational golden model of all checked arithmetic units (unsigned, mod 2^WIDTH).
module arith_golden
  import arith_result_checker_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [WIDTH-1:0] prod_low,
  output logic [WIDTH-1:0] prod_high,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  // Expected result of every unit for the operand pair.
  always_comb begin
    lt                    = in1 < in2;
    gt                    = in1 > in2;
    eq                    = in1 == in2;
    {carry, sum}          = {1'b0, in1} + {1'b0, in2};
    diff                  = in1 - in2;
    borrow                = in1 < in2;
    {prod_high, prod_low} = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
    if (in2 == '0) begin
      quot = DIV0_QUOT_ALL_ONES ? '1 : '0;
      rem  = in1;
    end else begin
      quot = in1 / in2;
      rem  = in1 % in2;
    end
  end

endmodule

// File: rtl/arith_result_checker.sv
// Response checker: accepts one vector per cycle, compares against the golden
// model two stages later, counts vectors/errors and captures the first failure.
// Handshake: a vector transfers on a cycle where in_valid && in_ready; in_ready
// depends only on registered state, never on in_valid.
module arith_result_checker
  import arith_result_checker_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 16,
  parameter int EXPECT_CNT = 2 ** (2 * WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic              lt,
  input  logic              gt,
  input  logic              eq,
  input  logic [WIDTH-1:0]  sum,
  input  logic              carry,
  input  logic [WIDTH-1:0]  diff,
  input  logic              borrow,
  input  logic [WIDTH-1:0]  prod_low,
  input  logic [WIDTH-1:0]  prod_high,
  input  logic [WIDTH-1:0]  quot,
  input  logic [WIDTH-1:0]  rem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              fail_valid,
  output logic [WIDTH-1:0]  fail_in1,
  output logic [WIDTH-1:0]  fail_in2,
  output logic [MASK_W-1:0] fail_mask,
  output state_t            dbg_state
);

  localparam int               VEC_W    = 8 * WIDTH + 5;
  localparam logic [CNT_W-1:0] EXPECT_V = CNT_W'(EXPECT_CNT);

  state_t              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic                s1_valid_q, s1_valid_d;
  logic                s2_valid_q, s2_valid_d;
  logic [MASK_W-1:0]   s2_mask_q, s2_mask_d;
  logic [WIDTH-1:0]    s2_in1_q, s2_in1_d, s2_in2_q, s2_in2_d;
  logic [CNT_W-1:0]    vec_count_q, vec_count_d, err_count_q, err_count_d;
  logic                fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0]    fail_in1_q, fail_in1_d, fail_in2_q, fail_in2_d;
  logic [MASK_W-1:0]   fail_mask_q, fail_mask_d;

  logic accept, start_run;
  logic [WIDTH-1:0] a_in1, a_in2, a_sum, a_diff, a_plo, a_phi, a_quot, a_rem;
  logic a_lt, a_gt, a_eq, a_carry, a_borrow;
  logic [WIDTH-1:0] g_sum, g_diff, g_plo, g_phi, g_quot, g_rem;
  logic g_lt, g_gt, g_eq, g_carry, g_borrow;
  logic [MASK_W-1:0] mask_now;

  assign in_ready  = (state_q == ST_RUN) && (vec_count_q < EXPECT_V);
  assign accept    = in_valid && in_ready;
  assign start_run = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  assign {a_in1, a_in2, a_sum, a_diff, a_plo, a_phi, a_quot, a_rem,
          a_lt, a_gt, a_eq, a_carry, a_borrow} = vec_q;

  arith_golden #(.WIDTH(WIDTH)) u_golden (
    .in1(a_in1), .in2(a_in2),
    .lt(g_lt), .gt(g_gt), .eq(g_eq),
    .sum(g_sum), .carry(g_carry),
    .diff(g_diff), .borrow(g_borrow),
    .prod_low(g_plo), .prod_high(g_phi),
    .quot(g_quot), .rem(g_rem)
  );

  // Per-unit mismatch of the S1 vector against the golden results.
  always_comb begin
    mask_now            = '0;
    mask_now[MASK_CMP]  = {a_lt, a_gt, a_eq} != {g_lt, g_gt, g_eq};
    mask_now[MASK_ADD]  = {a_carry, a_sum} != {g_carry, g_sum};
    mask_now[MASK_SUB]  = {a_borrow, a_diff} != {g_borrow, g_diff};
    mask_now[MASK_MUL]  = {a_phi, a_plo} != {g_phi, g_plo};
    mask_now[MASK_QUOT] = a_quot != g_quot;
    mask_now[MASK_REM]  = a_rem != g_rem;
  end

  // Run-control FSM next state; DRAIN ends once S1 is empty (S2 retires this edge).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_run) state_d = ST_RUN;
      ST_RUN:           if (vec_count_d == EXPECT_V) state_d = ST_DRAIN;
      ST_DRAIN:         if (!s1_valid_q) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Pipeline stages, counters and sticky first-fail capture.
  always_comb begin
    s1_valid_d   = accept;
    vec_d        = accept ? {in1, in2, sum, diff, prod_low, prod_high, quot, rem,
                             lt, gt, eq, carry, borrow} : vec_q;
    s2_valid_d   = s1_valid_q;
    s2_mask_d    = mask_now;
    s2_in1_d     = a_in1;
    s2_in2_d     = a_in2;
    vec_count_d  = vec_count_q;
    err_count_d  = err_count_q;
    fail_valid_d = fail_valid_q;
    fail_in1_d   = fail_in1_q;
    fail_in2_d   = fail_in2_q;
    fail_mask_d  = fail_mask_q;
    if (accept) vec_count_d = vec_count_q + CNT_W'(1);
    if (s2_valid_q && (|s2_mask_q)) begin
      if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      if (!fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_in1_d   = s2_in1_q;
        fail_in2_d   = s2_in2_q;
        fail_mask_d  = s2_mask_q;
      end
    end
    if (start_run) begin
      vec_count_d  = '0;
      err_count_d  = '0;
      fail_valid_d = 1'b0;
      fail_in1_d   = '0;
      fail_in2_d   = '0;
      fail_mask_d  = '0;
    end
  end

  // State registers with synchronous reset that also flushes the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_mask_q    <= '0;
      s2_in1_q     <= '0;
      s2_in2_q     <= '0;
      vec_count_q  <= '0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      fail_in1_q   <= '0;
      fail_in2_q   <= '0;
      fail_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s2_mask_q    <= s2_mask_d;
      s2_in1_q     <= s2_in1_d;
      s2_in2_q     <= s2_in2_d;
      vec_count_q  <= vec_count_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      fail_in1_q   <= fail_in1_d;
      fail_in2_q   <= fail_in2_d;
      fail_mask_q  <= fail_mask_d;
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = state_q == ST_DONE;
  assign pass       = done && (err_count_q == '0);
  assign vec_count  = vec_count_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_in1   = fail_in1_q;
  assign fail_in2   = fail_in2_q;
  assign fail_mask  = fail_mask_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_arith_result_checker.sv
// Bench for arith_result_checker: full operand sweeps with injected faults,
// expected run results queued at run start and checked when done rises.
module tb_arith_result_checker;
  import arith_result_checker_pkg::*;

  localparam int W  = 4;
  localparam int CW = 16;
  localparam int N  = 256;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start = 1'b0, in_valid = 1'b0, in_ready;
  logic [W-1:0] in1 = '0, in2 = '0, sum = '0, diff = '0, prod_low = '0, prod_high = '0;
  logic [W-1:0] quot = '0, rem = '0;
  logic lt = 1'b0, gt = 1'b0, eq = 1'b0, carry = 1'b0, borrow = 1'b0;
  logic busy, done, pass, fail_valid;
  logic [CW-1:0] vec_count, err_count;
  logic [W-1:0] fail_in1, fail_in2;
  logic [5:0] fail_mask;
  state_t dbg_state;

  arith_result_checker #(.WIDTH(W), .CNT_W(CW), .EXPECT_CNT(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .lt(lt), .gt(gt), .eq(eq), .sum(sum), .carry(carry),
    .diff(diff), .borrow(borrow), .prod_low(prod_low), .prod_high(prod_high),
    .quot(quot), .rem(rem), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .fail_valid(fail_valid),
    .fail_in1(fail_in1), .fail_in2(fail_in2), .fail_mask(fail_mask),
    .dbg_state(dbg_state)
  );

  // Scoreboard state
  int checks = 0;
  int failures = 0;
  int last_acc = 0;
  bit done_prev = 1'b0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_e;
  int fc[N];          // fault code per vector: 0 none, 1 cmp, 2 add, 3 sub, 4 mul, 5 quot, 6 rem
  logic [3:0] fx[N];  // nonzero corruption pattern

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ctrl"}, int'({in_ready, busy, done, pass, fail_valid, dbg_state}), 0);
    chk({name, "_vec_count"}, int'(vec_count), 0);
    chk({name, "_err_count"}, int'(err_count), 0);
    chk({name, "_fail_regs"}, int'({fail_in1, fail_in2, fail_mask}), 0);
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      fc[i] = 0;
      fx[i] = 4'h0;
    end
  endtask

  // Driver: correct unit outputs from plain arithmetic, then the planted fault.
  task automatic drive_vec(input int idx);
    int a, b, s, d, p;
    a = idx / 16; b = idx % 16; s = a + b; d = a - b; p = a * b;
    in1 = 4'(a); in2 = 4'(b);
    lt = (a < b); gt = (a > b); eq = (a == b);
    sum = 4'(s); carry = s[4];
    diff = 4'(d); borrow = (a < b);
    prod_low = 4'(p); prod_high = 4'(p >> 4);
    if (b == 0) begin quot = 4'hF; rem = 4'(a); end
    else begin quot = 4'(a / b); rem = 4'(a % b); end
    case (fc[idx])
      1: eq = ~eq;
      2: sum = sum ^ fx[idx];
      3: diff = diff ^ fx[idx];
      4: prod_high = prod_high ^ fx[idx];
      5: quot = quot ^ fx[idx];
      6: rem = rem ^ fx[idx];
      default: ;
    endcase
  endtask

  // Reference: expected end-of-run result from the planted fault list.
  task automatic push_expected();
    int errs = 0;
    bit fv = 1'b0;
    logic [3:0] f1 = '0, f2 = '0;
    logic [5:0] m = '0;
    for (int i = 0; i < N; i++) begin
      if (fc[i] != 0) begin
        errs++;
        if (!fv) begin
          fv = 1'b1;
          f1 = 4'(i / 16);
          f2 = 4'(i % 16);
          m = 6'(1 << (fc[i] - 1));
        end
      end
    end
    exp_q.push_back({16'(N), 16'(errs), (errs == 0), fv, f1, f2, m});
  endtask

  // Monitor: on each rising done, pop the expected run result and compare.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done expected=no_done");
      end else begin
        mon_e = exp_q.pop_front();
        chk("vec_count", int'(vec_count), int'(mon_e[47:32]));
        chk("err_count", int'(err_count), int'(mon_e[31:16]));
        chk("pass", int'(pass), int'(mon_e[15]));
        chk("fail_valid", int'(fail_valid), int'(mon_e[14]));
        chk("fail_in1", int'(fail_in1), int'(mon_e[13:10]));
        chk("fail_in2", int'(fail_in2), int'(mon_e[9:6]));
        chk("fail_mask", int'(fail_mask), int'(mon_e[5:0]));
        chk("done_latency", cyc - last_acc, 3);
        chk("busy_at_done", int'(busy), 0);
      end
    end
    done_prev = done;
  end

  task automatic run_sweep(input bit gaps, input bit noise, input int abort_after);
    bit phase = 1'b0;
    bit got;
    if (noise) begin
      for (int k = 0; k < 3; k++) begin
        drive_vec(int'($urandom_range(0, N - 1)));
        in_valid = 1'b1;
        @(posedge clk); #1;
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    if (abort_after == 0) push_expected();
    for (int idx = 0; idx < N; idx++) begin
      drive_vec(idx);
      got = 1'b0;
      if (gaps && idx == 50) start = 1'b1;
      for (int t = 0; t < 8 && !got; t++) begin
        in_valid = gaps ? phase : 1'b1;
        phase = ~phase;
        @(negedge clk);
        if (in_valid && in_ready) begin
          got = 1'b1;
          last_acc = cyc;
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=no_accept expected=accept idx=%0d", idx);
        in_valid = 1'b0;
        return;
      end
      if (abort_after != 0 && idx + 1 == abort_after) begin
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset_mid_run");
        @(posedge clk); #1;
        return;
      end
    end
    in_valid = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 8 && !got; t++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done expected=done");
    end
    @(posedge clk); #1;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_faults();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Clean sweep, back-to-back, with in_valid noise while idle
    run_sweep(1'b0, 1'b1, 0);

    // Single sum fault at in1=3, in2=5 (0x8 driven as 0x9)
    fc[3 * 16 + 5] = 2; fx[3 * 16 + 5] = 4'h1;
    run_sweep(1'b0, 1'b0, 0);
    clear_faults();

    // Divide by zero: in1=7, in2=0 with quot driven as 0
    fc[7 * 16] = 5; fx[7 * 16] = 4'hF;
    run_sweep(1'b0, 1'b0, 0);
    clear_faults();

    // Faults at vectors 10 and 20; first fail must stay on vector 10
    fc[10] = 3; fx[10] = 4'h2;
    fc[20] = 6; fx[20] = 4'h1;
    run_sweep(1'b0, 1'b0, 0);
    clear_faults();

    // Handshake gaps, idle noise, start pulse during RUN
    run_sweep(1'b1, 1'b1, 0);

    // Reset after 100 vectors, then a clean sweep
    run_sweep(1'b0, 1'b0, 100);
    run_sweep(1'b0, 1'b0, 0);

    // Randomized fault sets, always including the last vector
    for (int r = 0; r < 3; r++) begin
      clear_faults();
      for (int k = 0; k < 4; k++) begin
        int i;
        i = int'($urandom_range(0, N - 2));
        fc[i] = int'($urandom_range(1, 6));
        fx[i] = 4'($urandom_range(1, 15));
      end
      fc[N - 1] = int'($urandom_range(1, 6));
      fx[N - 1] = 4'($urandom_range(1, 15));
      run_sweep(1'($urandom_range(0, 1)), 1'b0, 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
